// File: rtl/fractal_sync_root_rsp.sv
`default_nettype none
// ============================================================================
// fractal_sync_root_rsp: buffers sync requests from the tree root and answers
// each with a wake (level, id) or error pulse. Optional: FRACTAL_SYNC_ROOT_RSP_STATS_EN
// Revision: 1.0
// ============================================================================
module fractal_sync_root_rsp #(
    parameter int AGGR_WIDTH  = 5,
    parameter int LVL_WIDTH   = 3,
    parameter int ID_WIDTH    = 5,
    parameter int LVL_OFFSET  = 0,
    parameter int FIFO_DEPTH  = 4,
    parameter int RSP_LATENCY = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_sync_i,
    input  logic [AGGR_WIDTH-1:0] req_aggr_i,
    input  logic [ID_WIDTH-1:0]   req_id_i,
    output logic                  rsp_wake_o,
    output logic [LVL_WIDTH-1:0]  rsp_lvl_o,
    output logic [ID_WIDTH-1:0]   rsp_id_o,
    output logic                  rsp_error_o,
    output logic                  overflow_o
`ifdef FRACTAL_SYNC_ROOT_RSP_STATS_EN
    ,
    output logic [15:0]           wake_cnt_o,
    output logic [15:0]           err_cnt_o
`endif
);

    localparam int ENTRY_W = AGGR_WIDTH + ID_WIDTH;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W   = $clog2(FIFO_DEPTH + 1);
    localparam int LAT_W   = (RSP_LATENCY > 0) ? $clog2(RSP_LATENCY + 1) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RSP_LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state;
    logic [ENTRY_W-1:0]    mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [OCC_W-1:0]      occ;
    logic [LAT_W-1:0]      cnt;
    logic [AGGR_WIDTH-1:0] held_aggr;
    logic [ID_WIDTH-1:0]   held_id;
    logic                  wake_q;
    logic                  err_q;
    logic [LVL_WIDTH-1:0]  lvl_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic                  overflow_q;
    logic [LVL_WIDTH-1:0]  lvl;
    logic [ENTRY_W-1:0]    head;
    logic                  empty;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  drop;

    assign head  = mem[rd_ptr];
    assign empty = (occ == '0);
    assign full  = (occ == FULL_OCC);
    assign pop   = ((state == IDLE) || (state == RESP)) && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push  = req_sync_i && (!full || pop);
    assign drop  = req_sync_i && full && !pop;

    always_comb begin
        lvl = '0;
        for (int i = 0; i < AGGR_WIDTH; i++) begin
            if (held_aggr[i]) lvl = LVL_WIDTH'(i + 1 + LVL_OFFSET);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {req_aggr_i, req_id_i};
                wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            if (push && !pop) occ <= occ + 1'b1;
            else if (pop && !push) occ <= occ - 1'b1;
            if (drop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            held_aggr <= '0;
            held_id   <= '0;
            wake_q    <= 1'b0;
            err_q     <= 1'b0;
            lvl_q     <= '0;
            id_q      <= '0;
        end else begin
            wake_q <= 1'b0;
            err_q  <= 1'b0;
            lvl_q  <= '0;
            id_q   <= '0;
            case (state)
                IDLE, RESP: begin
                    if (!empty) begin
                        {held_aggr, held_id} <= head;
                        cnt                  <= LAT_LOAD;
                        state                <= WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state  <= RESP;
                        wake_q <= |held_aggr;
                        err_q  <= ~|held_aggr;
                        lvl_q  <= (|held_aggr) ? lvl : '0;
                        id_q   <= held_id;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are forced low during reset so an in-flight response is aborted.
    assign rsp_wake_o  = wake_q & ~rst_i;
    assign rsp_error_o = err_q & ~rst_i;
    assign rsp_lvl_o   = lvl_q & {LVL_WIDTH{~rst_i}};
    assign rsp_id_o    = id_q & {ID_WIDTH{~rst_i}};
    assign overflow_o  = overflow_q & ~rst_i;

`ifdef FRACTAL_SYNC_ROOT_RSP_STATS_EN
    logic [15:0] wake_cnt;
    logic [15:0] err_cnt;
    logic [16:0] wake_sum;
    logic [16:0] err_sum;

    assign wake_sum = {1'b0, wake_cnt} + 17'(wake_q);
    assign err_sum  = {1'b0, err_cnt} + 17'(err_q) + 17'(drop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wake_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            wake_cnt <= wake_sum[16] ? 16'hFFFF : wake_sum[15:0];
            err_cnt  <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    assign wake_cnt_o = wake_cnt;
    assign err_cnt_o  = err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fractal_sync_root_rsp.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for fractal_sync_root_rsp: three instances (latency 0, latency 2,
// depth 2 / latency 4) checked against an expected-response scoreboard.
module tb_fractal_sync_root_rsp;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] aggr = '0;
    logic [4:0] id = '0;
    logic       sync0 = 1'b0, sync2 = 1'b0, syncf = 1'b0;

    logic       wake0, err0, ovf0, wake2, err2, ovf2, wakef, errf, ovff;
    logic [2:0] lvl0, lvl2, lvlf;
    logic [4:0] id0, id2, idf;
`ifdef FRACTAL_SYNC_ROOT_RSP_STATS_EN
    logic [15:0] wc0, ec0, wc2, ec2, wcf, ecf;
`endif

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic       wake;
        logic       err;
        logic [2:0] lvl;
        logic [4:0] id;
    } exp_t;

    typedef struct {
        logic [4:0] aggr;
        logic [4:0] id;
        logic       wake;
        logic       err;
        logic [2:0] lvl;
    } vec_t;

    exp_t q0[$], q2[$], qf[$];
    vec_t vecs[7];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fractal_sync_root_rsp dut0 (
        .clk_i(clk), .rst_i(rst), .req_sync_i(sync0), .req_aggr_i(aggr), .req_id_i(id),
        .rsp_wake_o(wake0), .rsp_lvl_o(lvl0), .rsp_id_o(id0), .rsp_error_o(err0),
        .overflow_o(ovf0)
`ifdef FRACTAL_SYNC_ROOT_RSP_STATS_EN
        , .wake_cnt_o(wc0), .err_cnt_o(ec0)
`endif
    );

    fractal_sync_root_rsp #(.RSP_LATENCY(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .req_sync_i(sync2), .req_aggr_i(aggr), .req_id_i(id),
        .rsp_wake_o(wake2), .rsp_lvl_o(lvl2), .rsp_id_o(id2), .rsp_error_o(err2),
        .overflow_o(ovf2)
`ifdef FRACTAL_SYNC_ROOT_RSP_STATS_EN
        , .wake_cnt_o(wc2), .err_cnt_o(ec2)
`endif
    );

    fractal_sync_root_rsp #(.FIFO_DEPTH(2), .RSP_LATENCY(4)) dutf (
        .clk_i(clk), .rst_i(rst), .req_sync_i(syncf), .req_aggr_i(aggr), .req_id_i(id),
        .rsp_wake_o(wakef), .rsp_lvl_o(lvlf), .rsp_id_o(idf), .rsp_error_o(errf),
        .overflow_o(ovff)
`ifdef FRACTAL_SYNC_ROOT_RSP_STATS_EN
        , .wake_cnt_o(wcf), .err_cnt_o(ecf)
`endif
    );

    task automatic check_rsp(input string nm, input bit has, input exp_t e,
                             input logic w, input logic er, input logic [2:0] l, input logic [4:0] i);
        logic       ew, eer;
        logic [2:0] el;
        logic [4:0] ei;
        ew = has ? e.wake : 1'b0;
        eer = has ? e.err : 1'b0;
        el = has ? e.lvl : 3'd0;
        ei = has ? e.id : 5'd0;
        checks++;
        if ({w, er, l, i} !== {ew, eer, el, ei}) begin
            errors++;
            $display("FAIL %s cyc %0d: got wake=%b err=%b lvl=%0d id=%0d, expected wake=%b err=%b lvl=%0d id=%0d",
                     nm, cyc, w, er, l, i, ew, eer, el, ei);
        end
    endtask

    task automatic check_val(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d: got %0d, expected %0d", nm, cyc, got, exp);
        end
    endtask

    task automatic missed(input string nm, input exp_t e);
        checks++;
        errors++;
        $display("FAIL %s missing response: got none at cyc %0d, expected wake=%b err=%b id=%0d",
                 nm, e.cyc, e.wake, e.err, e.id);
    endtask

    always @(negedge clk) begin : mon0
        exp_t e;
        bit   has;
        has = 1'b0;
        e = '{0, 1'b0, 1'b0, 3'd0, 5'd0};
        while (q0.size() > 0 && q0[0].cyc < cyc) missed("dut0", q0.pop_front());
        if (q0.size() > 0 && q0[0].cyc == cyc) begin
            e = q0.pop_front();
            has = 1'b1;
        end
        check_rsp("dut0", has, e, wake0, err0, lvl0, id0);
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        bit   has;
        has = 1'b0;
        e = '{0, 1'b0, 1'b0, 3'd0, 5'd0};
        while (q2.size() > 0 && q2[0].cyc < cyc) missed("dut2", q2.pop_front());
        if (q2.size() > 0 && q2[0].cyc == cyc) begin
            e = q2.pop_front();
            has = 1'b1;
        end
        check_rsp("dut2", has, e, wake2, err2, lvl2, id2);
    end

    always @(negedge clk) begin : monf
        exp_t e;
        bit   has;
        has = 1'b0;
        e = '{0, 1'b0, 1'b0, 3'd0, 5'd0};
        while (qf.size() > 0 && qf[0].cyc < cyc) missed("dutf", qf.pop_front());
        if (qf.size() > 0 && qf[0].cyc == cyc) begin
            e = qf.pop_front();
            has = 1'b1;
        end
        check_rsp("dutf", has, e, wakef, errf, lvlf, idf);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds the request for exactly one cycle on the selected instance.
    task automatic send(input int d, input logic [4:0] a, input logic [4:0] i);
        aggr = a;
        id = i;
        if (d == 0) sync0 = 1'b1;
        else if (d == 2) sync2 = 1'b1;
        else syncf = 1'b1;
        idle(1);
        sync0 = 1'b0;
        sync2 = 1'b0;
        syncf = 1'b0;
    endtask

    function automatic exp_t mk(input int c, input vec_t v);
        exp_t e;
        e.cyc = c;
        e.wake = v.wake;
        e.err = v.err;
        e.lvl = v.lvl;
        e.id = v.id;
        return e;
    endfunction

    initial begin
        int n;
        vecs[0] = '{5'b00001, 5'd0,  1'b1, 1'b0, 3'd1};
        vecs[1] = '{5'b00110, 5'd7,  1'b1, 1'b0, 3'd3};
        vecs[2] = '{5'b00000, 5'd3,  1'b0, 1'b1, 3'd0};
        vecs[3] = '{5'b10000, 5'd31, 1'b1, 1'b0, 3'd5};
        vecs[4] = '{5'b11111, 5'd12, 1'b1, 1'b0, 3'd5};
        vecs[5] = '{5'b01010, 5'd9,  1'b1, 1'b0, 3'd4};
        vecs[6] = '{5'b00010, 5'd1,  1'b1, 1'b0, 3'd2};

        // A request pulse held during reset must be discarded.
        rst = 1'b1;
        sync0 = 1'b1;
        aggr = 5'b00001;
        idle(3);
        sync0 = 1'b0;
        rst = 1'b0;
        check_val("ovf0_reset", int'(ovf0), 0);
        check_val("ovf2_reset", int'(ovf2), 0);
        check_val("ovff_reset", int'(ovff), 0);
        idle(6);

        foreach (vecs[k]) begin
            n = cyc;
            q0.push_back(mk(n + 3, vecs[k]));
            send(0, vecs[k].aggr, vecs[k].id);
            idle(5);
        end

        n = cyc;
        q2.push_back(mk(n + 5, vecs[1]));
        send(2, vecs[1].aggr, vecs[1].id);
        idle(8);

        // Depth 2, latency 4: three accepted, spaced 6 cycles, fourth dropped.
        n = cyc;
        qf.push_back(mk(n + 7, vecs[0]));
        qf.push_back(mk(n + 13, vecs[5]));
        qf.push_back(mk(n + 19, vecs[2]));
        send(1, vecs[0].aggr, vecs[0].id);
        send(1, vecs[5].aggr, vecs[5].id);
        send(1, vecs[2].aggr, vecs[2].id);
        check_val("ovff_before_drop", int'(ovff), 0);
        send(1, vecs[3].aggr, vecs[3].id);
        check_val("ovff_after_drop", int'(ovff), 1);
        idle(24);
        check_val("ovff_sticky", int'(ovff), 1);

        // Reset while dut2 is in WAIT: no response, overflow cleared.
        send(2, vecs[3].aggr, vecs[3].id);
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_val("ovff_cleared", int'(ovff), 0);
        idle(8);
        n = cyc;
        q2.push_back(mk(n + 5, vecs[5]));
        send(2, vecs[5].aggr, vecs[5].id);
        idle(8);

        // Reset during the RESP cycle of dut0 must suppress the pulse.
        send(0, vecs[4].aggr, vecs[4].id);
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(6);
        n = cyc;
        q0.push_back(mk(n + 3, vecs[6]));
        send(0, vecs[6].aggr, vecs[6].id);
        idle(6);

`ifdef FRACTAL_SYNC_ROOT_RSP_STATS_EN
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_val("wake_cnt_reset", int'(wc0), 0);
        for (int k = 0; k < 4; k++) begin
            n = cyc;
            q0.push_back(mk(n + 3, vecs[k]));
            send(0, vecs[k].aggr, vecs[k].id);
            idle(5);
        end
        check_val("wake_cnt", int'(wc0), 3);
        check_val("err_cnt", int'(ec0), 1);
`endif

        idle(10);
        check_val("q0_drained", q0.size(), 0);
        check_val("q2_drained", q2.size(), 0);
        check_val("qf_drained", qf.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, expected $finish before 200000 ns");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/fractal_sync_root_rsp.md
FRACTAL_SYNC_ROOT_RSP -- requirements
Module: fractal_sync_root_rsp

Interface
REQ-001: Parameter AGGR_WIDTH, default 5: width of the incoming aggregate field (the top node's out-port width).
REQ-002: Parameter LVL_WIDTH, default 3: width of the response level field.
REQ-003: Parameter ID_WIDTH, default 5: width of the barrier id field.
REQ-004: Parameter LVL_OFFSET, default 0: added to the computed level.
REQ-005: Parameter FIFO_DEPTH, default 4, minimum 1: number of pending requests buffered.
REQ-006: Parameter RSP_LATENCY, default 0: extra wait cycles before each response.
REQ-007: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-008: rst_i  input  1  reset, synchronous and active-high.
REQ-009: req_sync_i  input  1  one-cycle sync request pulse from the tree root out-port.
REQ-010: req_aggr_i  input  AGGR_WIDTH  request aggregate.
REQ-011: req_id_i  input  ID_WIDTH  request barrier id.
REQ-012: rsp_wake_o  output  1  one-cycle wake pulse.
REQ-013: rsp_lvl_o  output  LVL_WIDTH  level of the response.
REQ-014: rsp_id_o  output  ID_WIDTH  barrier id of the response.
REQ-015: rsp_error_o  output  1  one-cycle error pulse, in place of wake.
REQ-016: overflow_o  output  1  sticky flag: a request was dropped.

Function
REQ-017: The block SHALL sample the request bus in every cycle where req_sync_i=1 and push {aggr, id} into the FIFO; there is no backpressure.
REQ-018: If the FIFO is full and no pop occurs in the same cycle, the block SHALL drop the request and set overflow_o=1 until reset.
REQ-019: If the FIFO is full and a pop occurs in the same cycle, the block SHALL accept the push; FIFO occupancy stays at FIFO_DEPTH.
REQ-020: The FSM states SHALL be IDLE, WAIT and RESP.
REQ-021: IDLE, FIFO non-empty: pop the head into the hold register, load cnt=RSP_LATENCY and go to WAIT; otherwise stay in IDLE.
REQ-022: WAIT: if cnt=0, go to RESP; otherwise decrement cnt.
REQ-023: RESP: drive the response for exactly one cycle; if the FIFO is non-empty, pop, reload cnt and go to WAIT; otherwise go to IDLE.
REQ-024: Level computation SHALL be lvl = (index of the most significant 1 in the held aggr) + 1 + LVL_OFFSET, truncated to LVL_WIDTH.
REQ-025: In RESP with held aggr non-zero, the block SHALL drive rsp_wake_o=1, rsp_error_o=0, rsp_lvl_o=lvl and rsp_id_o=held id.
REQ-026: In RESP with held aggr=0, the block SHALL drive rsp_error_o=1, rsp_wake_o=0, rsp_lvl_o=0 and rsp_id_o=held id.
REQ-027: Outside RESP, the block SHALL drive rsp_wake_o, rsp_error_o, rsp_lvl_o and rsp_id_o to 0.
REQ-028: For a request in cycle N into an idle, empty block, the response SHALL appear in cycle N+3+RSP_LATENCY.
REQ-029: Back-to-back responses SHALL be spaced RSP_LATENCY+2 cycles apart.
REQ-030: Responses SHALL be issued in request arrival order.

Reset
REQ-031: When rst_i=1 at a clock edge, the block SHALL empty the FIFO, enter IDLE, clear cnt and the hold register, and clear overflow_o.
REQ-032: While in reset, all outputs SHALL be 0.
REQ-033: A request pulse in a reset cycle SHALL be discarded.
REQ-034: Reset asserted mid-WAIT or mid-RESP SHALL abort the pending response with no wake or error emitted.

Configuration
REQ-035: Macro FRACTAL_SYNC_ROOT_RSP_STATS_EN, when defined, SHALL add output wake_cnt_o (16 bits, counts wake pulses) and output err_cnt_o (16 bits, counts error pulses plus dropped requests).
REQ-036: Both counters SHALL saturate at 16'hFFFF and SHALL be cleared by reset.
REQ-037: Without FRACTAL_SYNC_ROOT_RSP_STATS_EN, the block SHALL have neither counter port nor counter logic, and all other behaviour SHALL be identical.

Verification
REQ-038: RSP_LATENCY=0; one request aggr=5'b00001, id=0 in cycle 10 -> rsp_wake_o=1 in cycle 13 only, rsp_lvl_o=1, rsp_id_o=0.
REQ-039: RSP_LATENCY=2; aggr=5'b00110, id=7 in cycle 10 -> wake in cycle 15, rsp_lvl_o=3, rsp_id_o=7.
REQ-040: Request with aggr=0, id=3 -> rsp_error_o=1 for one cycle with rsp_id_o=3, no wake pulse.
REQ-041: FIFO_DEPTH=2, RSP_LATENCY=4; 4 requests on consecutive cycles -> the first 3 are answered in order, spaced 6 cycles apart, the 4th is dropped and overflow_o=1.
REQ-042: Reset asserted during WAIT -> no response pulse; outputs 0; a new request after reset is answered with nominal latency.
REQ-043: With FRACTAL_SYNC_ROOT_RSP_STATS_EN defined, 3 valid requests plus 1 aggr=0 request -> wake_cnt_o=3, err_cnt_o=1.
